// File: rtl/obi_req_cut.sv
// OBI request cut: buffers upstream requests in a small FIFO so that the downstream
// request is driven from registered state only, and caps granted-but-unanswered requests.
module obi_req_cut #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // {req, we, be[3:0], addr[31:0], wdata[31:0]}
  input  logic [69:0] master_req_i,
  // {gnt, rvalid, rdata[31:0]}
  output logic [33:0] master_resp_o,
  output logic [69:0] slave_req_o,
  input  logic [33:0] slave_resp_i,
  output logic [3:0]  outstanding_o,
  output logic        idle_o,
  output logic        protocol_err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 69;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  occ_e          occ_q, occ_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    outst_q, outst_d;
  logic          err_q, err_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic          buf_full, buf_empty;
  logic          issue, push, pop;
  logic          slv_gnt, slv_rvalid;
  logic [PW-1:0] wr_ptr_inc, rd_ptr_inc;

  assign slv_gnt    = slave_resp_i[33];
  assign slv_rvalid = slave_resp_i[32];

  assign buf_full  = (occ_q == OCC_FULL);
  assign buf_empty = (occ_q == OCC_EMPTY);

  // Issue depends only on registered occupancy and count, never on the slave response.
  assign issue = !buf_empty && (outst_q < 4'(MAX_OUTSTANDING));
  assign push  = master_req_i[69] && !buf_full;
  assign pop   = issue && slv_gnt;

  assign wr_ptr_inc = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
  assign rd_ptr_inc = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_inc;
    if (pop)  rd_ptr_d = rd_ptr_inc;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) occ_d = OCC_PARTIAL;
      end
      OCC_PARTIAL: begin
        // Equal pointers after a one-sided move distinguish full from empty.
        if (push && !pop && (wr_ptr_inc == rd_ptr_q))
          occ_d = OCC_FULL;
        else if (pop && !push && (rd_ptr_inc == wr_ptr_q))
          occ_d = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (pop) occ_d = OCC_PARTIAL;
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    err_d   = err_q;
    if (pop && !slv_rvalid) begin
      outst_d = outst_q + 4'd1;
    end else if (!pop && slv_rvalid) begin
      if (outst_q == 4'd0) err_d = 1'b1;
      else                 outst_d = outst_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q    <= OCC_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      outst_q  <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset: occupancy alone says which entries are live.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (push && (wr_ptr_q == PW'(gi))) mem_q[gi] <= master_req_i[68:0];
    end
  end

  assign master_resp_o  = {push, slv_rvalid, slave_resp_i[31:0]};
  assign slave_req_o    = {issue, mem_q[rd_ptr_q]};
  assign outstanding_o  = outst_q;
  assign idle_o         = buf_empty && (outst_q == 4'd0);
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_obi_req_cut.sv
// Bench for obi_req_cut: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_obi_req_cut;

  localparam int DEPTH = 2;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        s_gnt, s_rvalid;
  logic [31:0] s_rdata;

  logic [69:0] master_req;
  logic [33:0] master_resp;
  logic [69:0] slave_req;
  logic [33:0] slave_resp;
  logic [3:0]  outstanding;
  logic        idle;
  logic        perr;

  assign master_req = {m_req, m_we, m_be, m_addr, m_wdata};
  assign slave_resp = {s_gnt, s_rvalid, s_rdata};

  obi_req_cut #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .master_req_i  (master_req),
    .master_resp_o (master_resp),
    .slave_req_o   (slave_req),
    .slave_resp_i  (slave_resp),
    .outstanding_o (outstanding),
    .idle_o        (idle),
    .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model: pending entries in order, outstanding count, sticky error.
  logic [68:0] mdl_q[$];
  int          mdl_out = 0;
  bit          mdl_err = 1'b0;

  task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    bit do_push, do_pop;
    @(posedge clk);
    if (rst) begin
      mdl_q.delete();
      mdl_out = 0;
      mdl_err = 1'b0;
    end else begin
      do_push = m_req && (mdl_q.size() < DEPTH);
      do_pop  = (mdl_q.size() > 0) && (mdl_out < MAXO) && s_gnt;
      if (do_pop)  void'(mdl_q.pop_front());
      if (do_push) mdl_q.push_back({m_we, m_be, m_addr, m_wdata});
      if (do_pop && !s_rvalid) mdl_out++;
      else if (!do_pop && s_rvalid) begin
        if (mdl_out == 0) mdl_err = 1'b1;
        else              mdl_out--;
      end
    end
  end

  initial forever begin
    bit exp_sreq;
    @(negedge clk);
    #4;
    if (chk_en) begin
      exp_sreq = (mdl_q.size() > 0) && (mdl_out < MAXO);
      chk("m_gnt", 69'(master_resp[33]), 69'(m_req && (mdl_q.size() < DEPTH)));
      chk("s_req", 69'(slave_req[69]), 69'(exp_sreq));
      if (exp_sreq) chk("s_payload", slave_req[68:0], mdl_q[0]);
      chk("m_rvalid", 69'(master_resp[32]), 69'(s_rvalid));
      chk("m_rdata", 69'(master_resp[31:0]), 69'(s_rdata));
      chk("outstanding", 69'(outstanding), 69'(mdl_out));
      chk("idle", 69'(idle), 69'((mdl_q.size() == 0) && (mdl_out == 0)));
      chk("perr", 69'(perr), 69'(mdl_err));
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_req = 0; m_we = 0; m_be = 4'h0; m_addr = '0; m_wdata = '0;
    s_gnt = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  task automatic set_m(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    m_req = req; m_we = we; m_be = 4'hF; m_addr = addr; m_wdata = wdata;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    idle_inputs();
    s_gnt = 1'b1;
    while (((mdl_q.size() > 0) || (mdl_out > 0)) && (c < 20)) begin
      s_rvalid = (mdl_out > 0);
      s_rdata  = $urandom;
      nxt();
      c++;
    end
    idle_inputs();
    #4;
    chk("drain_idle", 69'(idle), 69'(1));
    nxt();
  endtask

  initial begin
    logic [31:0] seen[$];
    int k, cyc;
    bit granted;

    idle_inputs();
    rst = 1'b1;
    repeat (2) nxt();
    rst = 1'b0;
    chk_en = 1'b1;

    // Single write through an always-granting slave.
    set_m(1, 1, 32'h0000_1000, 32'hDEAD_BEEF);
    s_gnt = 1;
    #4;
    chk("rst_idle", 69'(idle), 69'(1));
    chk("rst_sreq", 69'(slave_req[69]), 69'(0));
    chk("rst_outst", 69'(outstanding), 69'(0));
    chk("rst_gnt", 69'(master_resp[33]), 69'(1));
    nxt();
    m_req = 0;
    #4;
    chk("sw_sreq", 69'(slave_req[69]), 69'(1));
    chk("sw_addr", 69'(slave_req[63:32]), 69'(32'h0000_1000));
    chk("sw_wdata", 69'(slave_req[31:0]), 69'(32'hDEAD_BEEF));
    chk("sw_we", 69'(slave_req[68]), 69'(1));
    chk("sw_outst0", 69'(outstanding), 69'(0));
    nxt();
    s_rvalid = 1; s_rdata = 32'h1234_5678;
    #4;
    chk("sw_outst1", 69'(outstanding), 69'(1));
    chk("sw_rdata", 69'(master_resp[31:0]), 69'(32'h1234_5678));
    chk("sw_sreq_lo", 69'(slave_req[69]), 69'(0));
    nxt();
    s_rvalid = 0;
    #4;
    chk("sw_outst_end", 69'(outstanding), 69'(0));
    chk("sw_idle_end", 69'(idle), 69'(1));
    nxt();

    // Back-to-back reads against a stalled slave, then released.
    k = 0; cyc = 0;
    while ((seen.size() < 4) && (cyc < 30)) begin
      set_m(k < 4, 0, 32'(k * 4), 32'h0);
      s_gnt    = (cyc >= 3);
      s_rvalid = (mdl_out > 0);
      #4;
      if (cyc == 2) chk("b2b_gnt_drop", 69'(master_resp[33]), 69'(0));
      if (slave_req[69] && s_gnt) seen.push_back(slave_req[63:32]);
      granted = master_resp[33];
      nxt();
      if (granted) k++;
      cyc++;
    end
    chk("b2b_count", 69'(seen.size()), 69'(4));
    for (int i = 0; i < seen.size(); i++) chk("b2b_order", 69'(seen[i]), 69'(i * 4));
    drain();

    // Outstanding limit with rvalid withheld.
    s_gnt = 1;
    set_m(1, 0, 32'h100, 0); nxt();
    set_m(1, 0, 32'h104, 0); nxt();
    set_m(1, 0, 32'h108, 0); nxt();
    m_req = 0;
    #4;
    chk("lim_outst2", 69'(outstanding), 69'(2));
    chk("lim_sreq_lo", 69'(slave_req[69]), 69'(0));
    nxt();
    s_rvalid = 1;
    #4;
    chk("lim_hold", 69'(slave_req[69]), 69'(0));
    nxt();
    s_rvalid = 0;
    #4;
    chk("lim_outst1", 69'(outstanding), 69'(1));
    chk("lim_issue", 69'(slave_req[69]), 69'(1));
    chk("lim_addr", 69'(slave_req[63:32]), 69'(32'h108));
    nxt();
    drain();

    // Handshake and rvalid together at count 1; push and pop together.
    s_gnt = 1;
    set_m(1, 0, 32'h200, 0); nxt();
    set_m(1, 0, 32'h204, 0); nxt();
    set_m(1, 0, 32'h208, 0);
    s_rvalid = 1;
    #4;
    chk("sim_outst_pre", 69'(outstanding), 69'(1));
    nxt();
    idle_inputs();
    #4;
    chk("sim_outst_post", 69'(outstanding), 69'(1));
    chk("sim_sreq", 69'(slave_req[69]), 69'(1));
    chk("sim_addr", 69'(slave_req[63:32]), 69'(32'h208));
    nxt();
    drain();

    // rvalid while idle sets the sticky error.
    pulse_reset();
    s_rvalid = 1;
    #4;
    chk("perr_before", 69'(perr), 69'(0));
    nxt();
    s_rvalid = 0;
    #4;
    chk("perr_set", 69'(perr), 69'(1));
    chk("perr_outst", 69'(outstanding), 69'(0));
    nxt();
    #4;
    chk("perr_held", 69'(perr), 69'(1));
    nxt();

    // Reset mid-burst with two entries buffered and one outstanding.
    pulse_reset();
    s_gnt = 1;
    set_m(1, 0, 32'h300, 0); nxt();
    set_m(1, 0, 32'h304, 0); nxt();
    set_m(1, 0, 32'h308, 0);
    s_gnt = 0;
    nxt();
    m_req = 0;
    #4;
    chk("mid_outst", 69'(outstanding), 69'(1));
    chk("mid_gnt_full", 69'(master_resp[33]), 69'(0));
    rst = 1;
    nxt();
    rst = 0;
    s_rvalid = 1;
    #4;
    chk("mid_sreq", 69'(slave_req[69]), 69'(0));
    chk("mid_outst0", 69'(outstanding), 69'(0));
    chk("mid_idle", 69'(idle), 69'(1));
    chk("mid_perr0", 69'(perr), 69'(0));
    nxt();
    s_rvalid = 0;
    #4;
    chk("mid_perr1", 69'(perr), 69'(1));
    nxt();
    pulse_reset();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      m_req    = ($urandom_range(0, 9) < 6);
      m_we     = 1'($urandom);
      m_be     = 4'($urandom);
      m_addr   = $urandom;
      m_wdata  = $urandom;
      s_gnt    = ($urandom_range(0, 9) < 5);
      s_rdata  = $urandom;
      s_rvalid = (mdl_out > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) == 0);
      nxt();
    end
    rst = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obi_req_cut.md
OBI_REQ_CUT -- requirements
Module: obi_req_cut

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of request-buffer entries; legal values are 2 or 4.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 2, giving the maximum number of granted-but-unanswered downstream requests; legal values are 1 to 15.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous reset, active-high.
REQ-005 The block SHALL have port master_req_i, input, obi_req_t (req, we, be[3:0], addr[31:0], wdata[31:0]): the upstream master request.
REQ-006 The block SHALL have port master_resp_o, output, obi_resp_t (gnt, rvalid, rdata[31:0]): the response to the upstream master.
REQ-007 The block SHALL have port slave_req_o, output, obi_req_t: the request to one system-bus master port.
REQ-008 The block SHALL have port slave_resp_i, input, obi_resp_t: the response from that system-bus master port.
REQ-009 The block SHALL have port outstanding_o, output, 4 bits: the current outstanding count.
REQ-010 The block SHALL have port idle_o, output, 1 bit: high when the buffer is empty and outstanding_o is 0.
REQ-011 The block SHALL have port protocol_err_o, output, 1 bit: a sticky flag for an unexpected rvalid.

Function
REQ-012 master_resp_o.gnt SHALL equal master_req_i.req AND (buffer not full), with no dependency on any slave_resp_i field.
REQ-013 A master handshake (req and gnt high in the same cycle) SHALL push {we, be, addr, wdata} into the FIFO-ordered buffer.
REQ-014 A pushed request SHALL be visible on slave_req_o no earlier than the next cycle; minimum request latency is 1 cycle.
REQ-015 slave_req_o.req SHALL equal (buffer not empty) AND (count < MAX_OUTSTANDING).
REQ-016 slave_req_o.req SHALL be purely registered-state driven, with no combinational path from slave_resp_i.
REQ-017 slave_req_o payload SHALL be the head entry, and SHALL be held stable while slave_req_o.req is high and gnt is low.
REQ-018 A slave handshake (slave_req_o.req and slave_resp_i.gnt) SHALL pop the head entry.
REQ-019 A push and a pop in the same cycle SHALL leave occupancy unchanged, and this SHALL be permitted when the buffer is full only if the pop is decided on registered state; gnt stays per REQ-012, so full means no push.
REQ-020 The outstanding count SHALL increment on a slave handshake and decrement on slave_resp_i.rvalid; both in the same cycle SHALL leave it unchanged.
REQ-021 slave_resp_i.rvalid while count is 0 and no handshake occurs in that cycle SHALL leave the count at 0, with no underflow, and SHALL set protocol_err_o.
REQ-022 protocol_err_o SHALL stay set until reset.
REQ-023 master_resp_o.rvalid and master_resp_o.rdata SHALL pass combinationally from slave_resp_i, preserving order and adding zero latency.
REQ-024 Occupancy state SHALL be EMPTY, PARTIAL or FULL.
REQ-025 Occupancy transitions: EMPTY->PARTIAL on push; PARTIAL->FULL on push without pop when occupancy is DEPTH-1; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop without push when occupancy is 1.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 When count equals MAX_OUTSTANDING, slave_req_o.req SHALL be low and the head entry SHALL be retained.
REQ-028 The stalled head entry SHALL be issued in the cycle after the count drops.
REQ-029 A master request deasserted before grant SHALL NOT be pushed.

Reset
REQ-030 While rst_i is high at a clock edge, the buffer SHALL be empty, pointers 0, outstanding count 0 and protocol_err_o 0.
REQ-031 After reset, slave_req_o.req SHALL be 0, master_resp_o.gnt SHALL follow REQ-012 (buffer empty), and idle_o SHALL be 1.
REQ-032 Reset mid-operation SHALL discard buffered and outstanding requests, and the first slave rvalid after reset SHALL flag protocol_err_o.

Verification
REQ-033 Single write: master addr 0x0000_1000, wdata 0xDEAD_BEEF, slave gnt always 1, rvalid 1 cycle later -> slave_req_o.req high exactly 1 cycle after master grant with identical payload; outstanding_o goes 0->1->0; idle_o returns to 1.
REQ-034 Back-to-back: 4 reads 0x0, 0x4, 0x8, 0xC, slave gnt held 0 -> master gnt drops after 2 pushes (DEPTH=2); when gnt is released, slave sees all 4 addresses in order.
REQ-035 Outstanding limit: MAX_OUTSTANDING=2, slave grants immediately but withholds rvalid -> 2 slave handshakes, then slave_req_o.req low with outstanding_o=2; first rvalid -> next request issued the following cycle.
REQ-036 Simultaneous events: slave handshake and rvalid in the same cycle with count=1 -> count stays 1; push and pop in the same cycle -> occupancy constant.
REQ-037 Protocol error: rvalid while idle -> protocol_err_o=1 next cycle and held; outstanding_o stays 0.
REQ-038 Reset mid-burst: rst_i pulsed with 2 entries buffered and outstanding_o=1 -> next cycle buffer empty, slave_req_o.req=0, outstanding_o=0, idle_o=1.
